prog_interval_timer: RTL and testbench
======================================

// Module: prog_interval_timer
// PURPOSE
//  Runtime-programmable interval timer: a prescaler produces a tick every PRESCALE clocks;
//  the timer asserts done after INTERVAL ticks. Supports one-shot and periodic modes, pause,
//  abort and retrigger. Generalises the fixed one-second timer so that control FSMs in the
//  UART system (timeouts, inter-frame gaps, status blinkers) can share one timer type.
// PARAMETERS
//  PRESCALE_WIDTH  19  width of prescale counter and prescale_val (max prescale 2^W-1)
//  INTERVAL_WIDTH  8   width of tick counter, interval_val and elapsed
// PORTS
//  clk           in   1                clock; all logic on posedge
//  reset         in   1                synchronous, active-high reset
//  start         in   1                1-cycle request: latch config, (re)start timing
//  stop          in   1                abort: return to IDLE, no done
//  pause         in   1                level: hold all counters while high
//  periodic      in   1                mode latched at start: 1=periodic, 0=one-shot
//  prescale_val  in   PRESCALE_WIDTH   clocks per tick, latched at start
//  interval_val  in   INTERVAL_WIDTH   ticks per interval, latched at start
//  busy          out  1                high in RUN or PAUSED
//  tick          out  1                1-cycle pulse per prescaler wrap
//  done          out  1                1-cycle pulse at end of each interval
//  cfg_err       out  1                1-cycle pulse: start rejected (zero config)
//  elapsed       out  INTERVAL_WIDTH   ticks counted in current interval
// BEHAVIOUR
//  Reset: state=IDLE; busy, tick, done, cfg_err = 0; elapsed, prescale count, latches = 0.
//  All outputs registered. States: IDLE, RUN, PAUSED.
//  Priority each edge: reset > stop > start > pause > counting.
//  start (any state): if prescale_val==0 or interval_val==0 -> cfg_err pulse, state and
//   counters unchanged. Else latch P=prescale_val, I=interval_val, mode=periodic; clear
//   prescale count and elapsed; state=RUN. In RUN/PAUSED this is a retrigger; no done is
//   issued for the abandoned interval.
//  stop: any state -> IDLE; counters cleared; tick/done not asserted that cycle.
//  RUN: pause=1 -> PAUSED, no increment this edge. Else prescale count increments; at P-1
//   it wraps to 0 and tick=1 next cycle; elapsed increments on that wrap.
//  Interval end: wrap with elapsed==I-1 -> done=1 (same cycle as tick); elapsed -> 0;
//   one-shot -> IDLE (busy low in the same cycle as done); periodic -> stay RUN, no gap.
//  PAUSED: counters frozen; pause=0 -> RUN, counting resumes next edge.
//  Latency: start sampled at edge k -> n-th tick visible at cycle k+n*P; done at k+I*P.
//  P=1: tick every cycle. I=1: done with every tick.
//  elapsed never exceeds I-1. elapsed is unaffected by pause.
//  Config inputs are ignored outside a start cycle.
//  start and stop together: stop wins; start dropped, no cfg_err.
//  start and pause together: start wins; new interval begins in RUN.
// TESTING
//  P=4,I=3 one-shot, start@0 -> tick @4,8,12; done @12; busy 1 for 1..11, 0 from 12.
//  Same config, periodic -> done @12,24,36; elapsed sequence 0,1,2,0; busy stays 1.
//  One-shot, pause high cycles 5..9 -> ticks @4,13,17; done @17.
//  stop@7 -> no tick @8, busy 0 @8, elapsed 0. start@10 with P=4,I=3 retriggers -> done @22.
//  start with interval_val=0 -> cfg_err @1, busy stays 0.
//  start and stop both on cycle 3 -> cfg_err 0, state IDLE.
//  reset@6 mid-run -> all outputs 0 @7; no tick/done until next start.

Source files
------------

// File: rtl/prog_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : prog_interval_timer
// Description : Runtime-programmable interval timer. A prescaler divides clk
//               into ticks; done pulses after a programmed number of ticks.
//               One-shot or periodic, with pause, abort and retrigger.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_interval_timer #(
  parameter int PRESCALE_WIDTH = 19,
  parameter int INTERVAL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      periodic,
  input  logic [PRESCALE_WIDTH-1:0] prescale_val,
  input  logic [INTERVAL_WIDTH-1:0] interval_val,
  output logic                      busy,
  output logic                      tick,
  output logic                      done,
  output logic                      cfg_err,
  output logic [INTERVAL_WIDTH-1:0] elapsed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t                    state_q,   state_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q,    pcnt_d;
  logic [INTERVAL_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [PRESCALE_WIDTH-1:0] p_q,       p_d;
  logic [INTERVAL_WIDTH-1:0] i_q,       i_d;
  logic                      mode_q,    mode_d;
  logic                      busy_q,    busy_d;
  logic                      tick_q,    tick_d;
  logic                      done_q,    done_d;
  logic                      cfg_err_q, cfg_err_d;

  // Terminal counts of the latched configuration (both are >= 1 whenever
  // the timer is active, so the subtraction never underflows in use).
  logic [PRESCALE_WIDTH-1:0] w_p_last;
  logic [INTERVAL_WIDTH-1:0] w_i_last;
  assign w_p_last = p_q - PRESCALE_WIDTH'(1);
  assign w_i_last = i_q - INTERVAL_WIDTH'(1);

  // Next-state logic: stop > start > pause > counting; pulses default low.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    elapsed_d = elapsed_q;
    p_d       = p_q;
    i_d       = i_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      pcnt_d    = '0;
      elapsed_d = '0;
    end else if (start) begin
      if ((prescale_val == '0) || (interval_val == '0)) begin
        // Rejected request leaves the running interval untouched.
        cfg_err_d = 1'b1;
      end else begin
        p_d       = prescale_val;
        i_d       = interval_val;
        mode_d    = periodic;
        pcnt_d    = '0;
        elapsed_d = '0;
        state_d   = ST_RUN;
      end
    end else if (state_q != ST_IDLE) begin
      if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        // Leaving PAUSED counts on the same edge pause is seen low.
        state_d = ST_RUN;
        if (pcnt_q == w_p_last) begin
          pcnt_d = '0;
          tick_d = 1'b1;
          if (elapsed_q == w_i_last) begin
            done_d    = 1'b1;
            elapsed_d = '0;
            if (!mode_q) begin
              state_d = ST_IDLE;
            end
          end else begin
            elapsed_d = elapsed_q + INTERVAL_WIDTH'(1);
          end
        end else begin
          pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
        end
      end
    end

    // busy is registered from the next state so it drops with done.
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      elapsed_q <= '0;
      p_q       <= '0;
      i_q       <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      elapsed_q <= elapsed_d;
      p_q       <= p_d;
      i_q       <= i_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy    = busy_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign elapsed = elapsed_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_interval_timer
// Description : Directed self-checking bench for prog_interval_timer.
//               Cycle c below means "outputs just after the c-th rising edge
//               following the edge that sampled start".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_interval_timer;

  localparam int PRESCALE_WIDTH = 19;
  localparam int INTERVAL_WIDTH = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic                      stop;
  logic                      pause;
  logic                      periodic;
  logic [PRESCALE_WIDTH-1:0] prescale_val;
  logic [INTERVAL_WIDTH-1:0] interval_val;
  logic                      busy;
  logic                      tick;
  logic                      done;
  logic                      cfg_err;
  logic [INTERVAL_WIDTH-1:0] elapsed;

  int vectors     = 0;
  int miscompares = 0;

  prog_interval_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .INTERVAL_WIDTH(INTERVAL_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .periodic    (periodic),
    .prescale_val(prescale_val),
    .interval_val(interval_val),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .cfg_err     (cfg_err),
    .elapsed     (elapsed)
  );

  // 100 MHz nominal clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic etick, input logic edone,
                            input logic ebusy, input logic [31:0] eelapsed);
    check({tag, " tick"},    {31'd0, tick},    {31'd0, etick});
    check({tag, " done"},    {31'd0, done},    {31'd0, edone});
    check({tag, " busy"},    {31'd0, busy},    {31'd0, ebusy});
    check({tag, " elapsed"}, {24'd0, elapsed}, eelapsed);
  endtask

  // Issue a valid start, then scramble config inputs to show they are ignored.
  task automatic do_start(input int p, input int i, input logic per);
    start        = 1'b1;
    prescale_val = PRESCALE_WIDTH'(p);
    interval_val = INTERVAL_WIDTH'(i);
    periodic     = per;
    step();
    start        = 1'b0;
    prescale_val = PRESCALE_WIDTH'($urandom);
    interval_val = INTERVAL_WIDTH'($urandom);
    periodic     = ~per;
    check_outs("start c0", 1'b0, 1'b0, 1'b1, 0);
    check("start c0 cfg_err", {31'd0, cfg_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
    prescale_val = '0; interval_val = '0;

    // Reset state.
    step(); step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    check("reset cfg_err", {31'd0, cfg_err}, 32'd0);
    reset = 1'b0;
    step();

    // One-shot P=4 I=3: ticks 4,8,12; done 12; busy drops with done.
    do_start(4, 3, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      step();
      check_outs($sformatf("oneshot c%0d", c), (c % 4 == 0) && (c <= 12), c == 12,
                 c < 12, (c < 12) ? c / 4 : 0);
    end

    // Periodic P=4 I=3: done every 12, elapsed 0,1,2,0..., busy stays high.
    do_start(4, 3, 1'b1);
    for (int c = 1; c <= 36; c++) begin
      step();
      check_outs($sformatf("periodic c%0d", c), c % 4 == 0, c % 12 == 0, 1'b1, (c / 4) % 3);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("periodic stop", 1'b0, 1'b0, 1'b0, 0);

    // One-shot with pause sampled on edges 5..9: ticks 4,13,17; done 17.
    do_start(4, 3, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      pause = (c >= 5) && (c <= 9);
      step();
      check_outs($sformatf("pause c%0d", c), (c == 4) || (c == 13) || (c == 17), c == 17,
                 c < 17, (c < 4) ? 0 : (c < 13) ? 1 : (c < 17) ? 2 : 0);
    end
    pause = 1'b0;

    // Stop on the edge that would have produced the second tick.
    do_start(4, 3, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      stop = (c == 8);
      step();
      check_outs($sformatf("stop c%0d", c), c == 4, 1'b0, c < 8,
                 (c < 4) ? 0 : (c < 8) ? 1 : 0);
    end
    stop = 1'b0;

    // Retrigger at c10 while running: no done at 12, new interval ends at 22.
    do_start(4, 3, 1'b0);
    for (int c = 1; c <= 23; c++) begin
      if (c == 10) begin
        start = 1'b1; prescale_val = 19'd4; interval_val = 8'd3; periodic = 1'b0;
      end
      step();
      start = 1'b0;
      if (c < 10)
        check_outs($sformatf("retrig c%0d", c), c % 4 == 0, 1'b0, 1'b1, c / 4);
      else
        check_outs($sformatf("retrig c%0d", c), (c > 10) && ((c - 10) % 4 == 0) && (c <= 22),
                   c == 22, c < 22, (c < 22) ? (c - 10) / 4 : 0);
    end

    // Zero configuration rejected from IDLE.
    start = 1'b1; prescale_val = 19'd4; interval_val = 8'd0;
    step();
    start = 1'b0;
    check("cfg_err ival0", {31'd0, cfg_err}, 32'd1);
    check("cfg_err ival0 busy", {31'd0, busy}, 32'd0);
    step();
    check("cfg_err pulse end", {31'd0, cfg_err}, 32'd0);
    start = 1'b1; prescale_val = 19'd0; interval_val = 8'd3;
    step();
    start = 1'b0;
    check("cfg_err pval0", {31'd0, cfg_err}, 32'd1);
    check("cfg_err pval0 busy", {31'd0, busy}, 32'd0);

    // Zero configuration rejected while running: stays busy.
    do_start(4, 3, 1'b1);
    step();
    start = 1'b1; prescale_val = 19'd0; interval_val = 8'd0;
    step();
    start = 1'b0;
    check("cfg_err run", {31'd0, cfg_err}, 32'd1);
    check("cfg_err run busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // start and stop together: stop wins, no cfg_err even with zero config.
    start = 1'b1; stop = 1'b1; prescale_val = 19'd4; interval_val = 8'd3;
    step();
    check("start+stop cfg_err", {31'd0, cfg_err}, 32'd0);
    check("start+stop busy", {31'd0, busy}, 32'd0);
    interval_val = 8'd0;
    step();
    start = 1'b0; stop = 1'b0;
    check("start+stop zero cfg_err", {31'd0, cfg_err}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      check_outs($sformatf("start+stop idle c%0d", c), 1'b0, 1'b0, 1'b0, 0);
    end

    // start and pause together: start wins; P=1 I=2 one-shot.
    pause = 1'b1;
    do_start(1, 2, 1'b0);
    pause = 1'b0;
    step();
    check_outs("start+pause c1", 1'b1, 1'b0, 1'b1, 1);
    step();
    check_outs("start+pause c2", 1'b1, 1'b1, 1'b0, 0);

    // P=1 I=1 periodic: tick and done every cycle.
    do_start(1, 1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_outs($sformatf("p1i1 per c%0d", c), 1'b1, 1'b1, 1'b1, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("p1i1 stop", 1'b0, 1'b0, 1'b0, 0);

    // P=1 I=1 one-shot: single done, busy low with it.
    do_start(1, 1, 1'b0);
    step();
    check_outs("p1i1 oneshot c1", 1'b1, 1'b1, 1'b0, 0);
    step();
    check_outs("p1i1 oneshot c2", 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-run clears everything; nothing restarts afterwards.
    do_start(2, 3, 1'b1);
    for (int c = 1; c <= 5; c++) step();
    check_outs("prereset c5", 1'b0, 1'b0, 1'b1, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_outs("midreset", 1'b0, 1'b0, 1'b0, 0);
    check("midreset cfg_err", {31'd0, cfg_err}, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("postreset c%0d", c), 1'b0, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
